// File: rtl/bcd_update_scheduler_pkg.sv
// Shared definitions for the per-frame BCD update scheduler.
package bcd_update_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CONV_PTS   = 3'd1,
    ST_CONV_LINES = 3'd2,
    ST_CONV_LVL   = 3'd3,
    ST_COMMIT     = 3'd4
  } sched_state_t;

  // Cycles from a sampled start to the done pulse of the serial converter.
  function automatic int conv_latency(input int binary_bits);
    return binary_bits + 1;
  endfunction

  // Latency with the default 26-bit converter input.
  localparam int CONV_LATENCY = 27;

  // The single level digit saturates at 9.
  localparam logic [3:0] LEVEL_SAT = 4'h9;

endpackage

// File: rtl/bcd_update_scheduler_bin2bcd_serial.sv
// Serial double-dabble converter: one add-3-then-shift step per cycle.
// done pulses in the cycle after the last shift, with bcd_out valid.
module bin2bcd_serial
  import bcd_update_scheduler_pkg::*;
#(
  parameter int BINARY_BITS = 26,
  parameter int BCD_DIGITS  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BINARY_BITS-1:0]  bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd_out
);

  localparam int CNT_W = $clog2(BINARY_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(conv_latency(BINARY_BITS) - 1);

  logic [BINARY_BITS-1:0]  bin_q;
  logic [4*BCD_DIGITS-1:0] bcd_q;
  logic [4*BCD_DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;
  logic                    done_q;

  // Add 3 to every digit that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Shift engine with a down-counter that ends the conversion at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          bin_q  <= bin_in;
          bcd_q  <= '0;
          cnt_q  <= CNT_LOAD;
          busy_q <= 1'b1;
        end
      end else begin
        bcd_q <= {bcd_adj[4*BCD_DIGITS-2:0], bin_q[BINARY_BITS-1]};
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/bcd_update_scheduler.sv
// Once per frame, converts points, lines and level to BCD through one shared
// serial converter and commits all three results together.
//
// state         | meaning
// ST_IDLE       | waiting for frame_start; snapshot taken on acceptance
// ST_CONV_PTS   | converting the points snapshot
// ST_CONV_LINES | converting the lines snapshot
// ST_CONV_LVL   | converting the zero-extended level snapshot
// ST_COMMIT     | copying pending results to the outputs in one cycle
module bcd_update_scheduler
  import bcd_update_scheduler_pkg::*;
#(
  parameter int BINARY_BITS = 26,
  parameter int BCD_DIGITS  = 8,
  parameter int LEVEL_BITS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [BINARY_BITS-1:0]  game_points,
  input  logic [BINARY_BITS-1:0]  game_lines,
  input  logic [LEVEL_BITS-1:0]   game_level,
  output logic [4*BCD_DIGITS-1:0] points_bcd,
  output logic [4*BCD_DIGITS-1:0] lines_bcd,
  output logic [3:0]              level_bcd,
  output logic                    level_clamped,
  output logic                    bcd_update,
  output logic                    busy,
  output logic                    overrun
);

  sched_state_t state_q, state_d;

  logic                    launch_d, launch_q;
  logic                    take_snap;
  logic                    latch_pts, latch_lines, latch_lvl, do_commit;

  logic [BINARY_BITS-1:0]  pts_snap, lines_snap;
  logic [LEVEL_BITS-1:0]   lvl_snap;
  logic [4*BCD_DIGITS-1:0] pts_pend, lines_pend;
  logic [3:0]              lvl_pend;
  logic                    clamp_pend;

  logic                    conv_start, conv_busy, conv_done;
  logic [BINARY_BITS-1:0]  conv_in;
  logic [4*BCD_DIGITS-1:0] conv_bcd;
  logic                    lvl_over;

  // Next state, one-shot converter launch on each conversion-state entry.
  always_comb begin
    state_d     = state_q;
    launch_d    = 1'b0;
    take_snap   = 1'b0;
    latch_pts   = 1'b0;
    latch_lines = 1'b0;
    latch_lvl   = 1'b0;
    do_commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          take_snap = 1'b1;
          launch_d  = 1'b1;
          state_d   = ST_CONV_PTS;
        end
      end
      ST_CONV_PTS: begin
        if (conv_done) begin
          latch_pts = 1'b1;
          launch_d  = 1'b1;
          state_d   = ST_CONV_LINES;
        end
      end
      ST_CONV_LINES: begin
        if (conv_done) begin
          latch_lines = 1'b1;
          launch_d    = 1'b1;
          state_d     = ST_CONV_LVL;
        end
      end
      ST_CONV_LVL: begin
        if (conv_done) begin
          latch_lvl = 1'b1;
          state_d   = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        do_commit = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and the registered launch pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
    end
  end

  // Input snapshot, so later input changes cannot leak into this update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pts_snap   <= '0;
      lines_snap <= '0;
      lvl_snap   <= '0;
    end else if (take_snap) begin
      pts_snap   <= game_points;
      lines_snap <= game_lines;
      lvl_snap   <= game_level;
    end
  end

  // Converter input follows the value currently being converted.
  always_comb begin
    conv_in = '0;
    case (state_q)
      ST_CONV_PTS:   conv_in = pts_snap;
      ST_CONV_LINES: conv_in = lines_snap;
      ST_CONV_LVL:   conv_in = BINARY_BITS'(lvl_snap);
      default:       conv_in = '0;
    endcase
  end

  assign conv_start = launch_q & ~conv_busy;
  assign lvl_over   = |conv_bcd[4*BCD_DIGITS-1:4];

  bin2bcd_serial #(
    .BINARY_BITS(BINARY_BITS),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .bin_in (conv_in),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd_out(conv_bcd)
  );

  // Pending results collect each conversion until the whole set is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      pts_pend   <= '0;
      lines_pend <= '0;
      lvl_pend   <= '0;
      clamp_pend <= 1'b0;
    end else begin
      if (latch_pts)   pts_pend   <= conv_bcd;
      if (latch_lines) lines_pend <= conv_bcd;
      if (latch_lvl) begin
        lvl_pend   <= lvl_over ? LEVEL_SAT : conv_bcd[3:0];
        clamp_pend <= lvl_over;
      end
    end
  end

  // Visible outputs change only here, all in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      points_bcd    <= '0;
      lines_bcd     <= '0;
      level_bcd     <= '0;
      level_clamped <= 1'b0;
      bcd_update    <= 1'b0;
    end else begin
      bcd_update <= do_commit;
      if (do_commit) begin
        points_bcd    <= pts_pend;
        lines_bcd     <= lines_pend;
        level_bcd     <= lvl_pend;
        level_clamped <= clamp_pend;
      end
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign overrun = frame_start & busy;

endmodule

// File: tb/tb_bcd_update_scheduler.sv
// Self-checking bench for bcd_update_scheduler: vector table, directed
// corner sequences and randomized frames against a decimal reference model.
module tb_bcd_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [25:0] game_points, game_lines;
  logic [3:0]  game_level;
  logic [31:0] points_bcd, lines_bcd;
  logic [3:0]  level_bcd;
  logic        level_clamped, bcd_update, busy, overrun;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bcd_update_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .game_points  (game_points),
    .game_lines   (game_lines),
    .game_level   (game_level),
    .points_bcd   (points_bcd),
    .lines_bcd    (lines_bcd),
    .level_bcd    (level_bcd),
    .level_clamped(level_clamped),
    .bcd_update   (bcd_update),
    .busy         (busy),
    .overrun      (overrun)
  );

  typedef struct {
    logic [25:0] pts;
    logic [25:0] lns;
    logic [3:0]  lvl;
    logic [31:0] exp_pts;
    logic [31:0] exp_lns;
    logic [3:0]  exp_lvl;
    logic        exp_clamp;
  } vec_t;

  vec_t vecs[5];

  // Decimal digits by repeated division.
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame starting now (cycle 0). change_at: cycle at which
  // game_points is overwritten with 1. ovr_at: cycle of an extra frame_start.
  task automatic run_frame(input logic [25:0] p, input logic [25:0] l, input logic [3:0] v,
                           input int change_at, input int ovr_at,
                           input logic [31:0] ep, input logic [31:0] el,
                           input logic [3:0] ev, input logic ec, input string tag);
    int upd_cnt   = 0;
    int upd_cyc   = -1;
    int stray_ovr = 0;
    game_points = p;
    game_lines  = l;
    game_level  = v;
    frame_start = 1'b1;
    #1;
    check({tag, "_busy_c0"}, 64'(busy), 64'd0);
    for (int c = 1; c <= 100; c++) begin
      tick();
      frame_start = 1'b0;
      if (c == change_at) begin
        game_points = 26'd1;
        game_lines  = 26'd2;
        game_level  = 4'd5;
      end
      if (c == ovr_at) begin
        frame_start = 1'b1;
        #1;
        check({tag, "_overrun"}, 64'(overrun), 64'd1);
        check({tag, "_busy_ovr"}, 64'(busy), 64'd1);
      end else begin
        #1;
        if (overrun) stray_ovr++;
      end
      if (bcd_update) begin
        upd_cnt++;
        if (upd_cyc < 0) upd_cyc = c;
      end
      if (c == 1)  check({tag, "_busy_c1"},  64'(busy), 64'd1);
      if (c == 85) begin
        check({tag, "_busy_c85"}, 64'(busy), 64'd1);
        if (upd_cnt == 0 && points_bcd === ep && ep !== points_bcd) n_checks += 0;
      end
      if (c == 86) check({tag, "_busy_c86"}, 64'(busy), 64'd0);
    end
    check({tag, "_upd_count"}, 64'(upd_cnt), 64'd1);
    check({tag, "_upd_cycle"}, 64'(upd_cyc), 64'd86);
    check({tag, "_stray_ovr"}, 64'(stray_ovr), 64'd0);
    check({tag, "_points"}, 64'(points_bcd), 64'(ep));
    check({tag, "_lines"},  64'(lines_bcd),  64'(el));
    check({tag, "_level"},  64'(level_bcd),  64'(ev));
    check({tag, "_clamp"},  64'(level_clamped), 64'(ec));
  endtask

  initial begin
    int bad_upd, bad_busy;
    vecs[0] = '{26'd12345678, 26'd0,        4'd3,  32'h12345678, 32'h00000000, 4'h3, 1'b0};
    vecs[1] = '{26'd67108863, 26'd67108863, 4'd15, 32'h67108863, 32'h67108863, 4'h9, 1'b1};
    vecs[2] = '{26'd9,        26'd10,       4'd9,  32'h00000009, 32'h00000010, 4'h9, 1'b0};
    vecs[3] = '{26'd1000000,  26'd42,       4'd10, 32'h01000000, 32'h00000042, 4'h9, 1'b1};
    vecs[4] = '{26'd0,        26'd99999,    4'd0,  32'h00000000, 32'h00099999, 4'h0, 1'b0};

    rst = 1'b1;
    frame_start = 1'b0;
    game_points = '0;
    game_lines  = '0;
    game_level  = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset.
    bad_upd = 0;
    bad_busy = 0;
    check("rst_points", 64'(points_bcd), 64'd0);
    check("rst_lines",  64'(lines_bcd),  64'd0);
    check("rst_level",  64'(level_bcd),  64'd0);
    check("rst_clamp",  64'(level_clamped), 64'd0);
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (bcd_update) bad_upd++;
      if (busy || overrun) bad_busy++;
    end
    check("idle_bcd_update", 64'(bad_upd), 64'd0);
    check("idle_busy", 64'(bad_busy), 64'd0);
    check("idle_points", 64'(points_bcd), 64'd0);

    // Vector table.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].pts, vecs[i].lns, vecs[i].lvl, -1, -1,
                vecs[i].exp_pts, vecs[i].exp_lns, vecs[i].exp_lvl, vecs[i].exp_clamp,
                $sformatf("vec%0d", i));
    end

    // Snapshot isolation, then the changed value on the next frame.
    run_frame(26'd12345678, 26'd777, 4'd3, 5, -1,
              32'h12345678, 32'h00000777, 4'h3, 1'b0, "snap");
    run_frame(26'd1, 26'd2, 4'd5, -1, -1,
              32'h00000001, 32'h00000002, 4'h5, 1'b0, "snap2");

    // frame_start while busy, including in the commit cycle.
    run_frame(26'd4321, 26'd8765, 4'd7, -1, 40,
              32'h00004321, 32'h00008765, 4'h7, 1'b0, "ovr40");
    run_frame(26'd55, 26'd66, 4'd2, -1, 85,
              32'h00000055, 32'h00000066, 4'h2, 1'b0, "ovr85");

    // Reset in the middle of a conversion.
    game_points = 26'd999;
    game_lines  = 26'd888;
    game_level  = 4'd4;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (39) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy",   64'(busy), 64'd0);
    check("midrst_points", 64'(points_bcd), 64'd0);
    check("midrst_lines",  64'(lines_bcd), 64'd0);
    check("midrst_level",  64'(level_bcd), 64'd0);
    check("midrst_update", 64'(bcd_update), 64'd0);
    run_frame(26'd31415926, 26'd2718, 4'd8, -1, -1,
              32'h31415926, 32'h00002718, 4'h8, 1'b0, "postrst");

    // Randomized frames against the decimal model.
    for (int k = 0; k < 10; k++) begin
      logic [25:0] rp, rl;
      logic [3:0]  rv;
      int ca, oa;
      rp = 26'($urandom_range(0, 67108863));
      rl = 26'($urandom_range(0, 67108863));
      rv = 4'($urandom_range(0, 15));
      ca = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 84)) : -1;
      oa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 85)) : -1;
      run_frame(rp, rl, rv, ca, oa,
                to_bcd(int'(rp)), to_bcd(int'(rl)),
                (rv > 4'd9) ? 4'h9 : rv, (rv > 4'd9),
                $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/bcd_update_scheduler.md
Name: bcd_update_scheduler

Overview:
- Converts the three game counters (points, lines, level) to BCD once per video frame, during vertical blanking.
- All three values share one serial double-dabble converter.
- Holds the BCD results in registers so the number-drawing logic sees stable values for the whole active frame.
- Sits between the game core and the VGA number renderers, in the vga clock domain.

Parameters:
- BINARY_BITS, 26, width of the points and lines inputs and of the converter input.
- BCD_DIGITS, 8, number of digits produced by the converter (4*BCD_DIGITS output bits).
- LEVEL_BITS, 4, width of the level input.

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle pulse at start of vertical blanking (cntr_vr==600, cntr_hr==0)
- game_points  in  BINARY_BITS  binary score
- game_lines  in  BINARY_BITS  binary cleared-line count
- game_level  in  LEVEL_BITS  binary level
- points_bcd  out  4*BCD_DIGITS  registered BCD score
- lines_bcd  out  4*BCD_DIGITS  registered BCD lines
- level_bcd  out  4  registered BCD level digit
- level_clamped  out  1  level_bcd was saturated at the last commit
- bcd_update  out  1  one-cycle pulse in the cycle the new outputs first appear
- busy  out  1  high from the cycle after accepted frame_start through the COMMIT cycle
- overrun  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all outputs 0; FSM in IDLE; snapshot registers 0. A reset mid-conversion aborts the conversion and returns to IDLE; outputs go to 0.
- FSM states: IDLE, CONV_PTS, CONV_LINES, CONV_LVL, COMMIT.
- IDLE + frame_start at cycle 0:
  - Snapshot registers capture all three inputs at the end of cycle 0.
  - Go to CONV_PTS; converter start is asserted in cycle 1.
- Converter handshake:
  - start is sampled when the converter is idle.
  - BINARY_BITS shift cycles follow, then done pulses high for 1 cycle with result valid.
  - done occurs at start_cycle + BINARY_BITS + 1 (27 cycles later with defaults).
  - start is ignored while the converter is busy.
- CONV_PTS: on done (cycle 28), latch the result into a pending register; go to CONV_LINES; start asserted in cycle 29.
- CONV_LINES: done at cycle 56 → latch; go to CONV_LVL; start in cycle 57.
- CONV_LVL:
  - Input is game_level zero-extended to BINARY_BITS.
  - done at cycle 84 → latch; go to COMMIT in cycle 85.
- COMMIT (cycle 85):
  - points_bcd, lines_bcd, level_bcd and level_clamped update at the end of cycle 85, together.
  - bcd_update is high in cycle 86. FSM returns to IDLE in cycle 86.
  - Total latency: frame_start to visible outputs = 86 cycles with defaults.
- Consistency: outputs never show a mix of old and new values. Input changes after cycle 0 do not affect the current update.
- Level clamp: if the converter result for level is > 9 (any nonzero digit above digit 0), level_bcd = 4'h9 and level_clamped = 1. Otherwise level_bcd = digit 0 and level_clamped = 0.
- Range: 2^26-1 = 67108863 fits in 8 digits; no points/lines overflow path is required.
- frame_start while busy: ignored (no queueing); overrun pulses in that cycle. frame_start in COMMIT also counts as busy.
- busy is low in IDLE, including the cycle frame_start is sampled.

Decomposition:
- Shared package holds:
  - FSM state encoding for the scheduler.
  - A constant for converter latency (BINARY_BITS+1).
  - A constant for the level saturation value (4'h9).
- One sub-module, bin2bcd_serial: parameterized by BINARY_BITS and BCD_DIGITS; ports clk, rst, start, bin_in, busy, done, bcd_out; add-3-then-shift, one bit per cycle.

Test Plan:
- Reset then idle for 2000 cycles → all outputs 0, bcd_update never asserted, busy 0.
- points=12345678, lines=0, level=3, frame_start at cycle 0 → bcd_update at cycle 86; points_bcd=32'h12345678, lines_bcd=0, level_bcd=4'h3, level_clamped=0.
- points=lines=67108863, level=15 → points_bcd=lines_bcd=32'h67108863, level_bcd=4'h9, level_clamped=1.
- Snapshot then change inputs at cycle 5 (points=1) → committed points_bcd reflects the cycle-0 value. A second frame_start afterwards yields 32'h00000001.
- frame_start again at cycle 40 → overrun pulses at cycle 40, busy stays 1, single bcd_update at cycle 86.
- rst asserted at cycle 40 of a conversion → next cycle outputs 0, busy 0. A fresh frame_start converts correctly with the same 86-cycle latency.
